// File: rtl/wshb_arb_pkg.sv
// Shared types and widths for the two-master Wishbone arbiter.
package wshb_arb_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} arb_state_t;

    // Master-to-slave request bundle: everything that is routed towards the slave port.
    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
        logic [2:0]       cti;
        logic [1:0]       bte;
    } wb_req_t;

endpackage

// File: rtl/wshb_mux.sv
// Combinational 2:1 selection of the owning master's request bundle onto the slave port.
module wshb_mux
    import wshb_arb_pkg::*;
(
    input  arb_state_t i_state,
    input  wb_req_t    i_m0,
    input  wb_req_t    i_m1,
    output wb_req_t    o_s
);

    always_comb begin
        o_s = '0;
        case (i_state)
            GRANT0:  o_s = i_m0;
            GRANT1:  o_s = i_m1;
            default: o_s = '0;
        endcase
    end

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone classic arbiter with bounded-length grants onto one slave port.
// state  | meaning
// IDLE   | no owner, slave port driven to zero
// GRANT0 | master 0 (video reader) owns the slave
// GRANT1 | master 1 owns the slave
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [DAT_W-1:0] m0_dat_ms,
    input  logic [SEL_W-1:0] m0_sel,
    input  logic [2:0]       m0_cti,
    input  logic [1:0]       m0_bte,
    output logic             m0_ack,
    output logic [DAT_W-1:0] m0_dat_sm,

    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [DAT_W-1:0] m1_dat_ms,
    input  logic [SEL_W-1:0] m1_sel,
    input  logic [2:0]       m1_cti,
    input  logic [1:0]       m1_bte,
    output logic             m1_ack,
    output logic [DAT_W-1:0] m1_dat_sm,

    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [ADR_W-1:0] s_adr,
    output logic [DAT_W-1:0] s_dat_ms,
    output logic [SEL_W-1:0] s_sel,
    output logic [2:0]       s_cti,
    output logic [1:0]       s_bte,
    input  logic             s_ack,
    input  logic [DAT_W-1:0] s_dat_sm
);

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    arb_state_t r_state;
    arb_state_t w_next;
    logic [7:0] r_burst_cnt;
    logic       w_granted;
    wb_req_t    w_m0;
    wb_req_t    w_m1;
    wb_req_t    w_s;

    assign w_m0 = '{cyc: m0_cyc, stb: m0_stb, we: m0_we, adr: m0_adr,
                    dat: m0_dat_ms, sel: m0_sel, cti: m0_cti, bte: m0_bte};
    assign w_m1 = '{cyc: m1_cyc, stb: m1_stb, we: m1_we, adr: m1_adr,
                    dat: m1_dat_ms, sel: m1_sel, cti: m1_cti, bte: m1_bte};

    wshb_mux u_mux (
        .i_state (r_state),
        .i_m0    (w_m0),
        .i_m1    (w_m1),
        .o_s     (w_s)
    );

    assign s_cyc    = w_s.cyc;
    assign s_stb    = w_s.stb;
    assign s_we     = w_s.we;
    assign s_adr    = w_s.adr;
    assign s_dat_ms = w_s.dat;
    assign s_sel    = w_s.sel;
    assign s_cti    = w_s.cti;
    assign s_bte    = w_s.bte;

    assign m0_ack    = s_ack & (r_state == GRANT0);
    assign m1_ack    = s_ack & (r_state == GRANT1);
    assign m0_dat_sm = s_dat_sm;
    assign m1_dat_sm = s_dat_sm;

    assign w_granted = (r_state == GRANT0) || (r_state == GRANT1);

    // Owner dropping cyc outranks the burst limit, so an ack on the last beat with cyc low
    // still follows the release path.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (m0_cyc)      w_next = GRANT0;
                else if (m1_cyc) w_next = GRANT1;
            end
            GRANT0: begin
                if (!m0_cyc)
                    w_next = m1_cyc ? GRANT1 : IDLE;
                else if (s_ack && (r_burst_cnt == BURST_LAST) && m1_cyc)
                    w_next = GRANT1;
            end
            GRANT1: begin
                if (!m1_cyc)
                    w_next = m0_cyc ? GRANT0 : IDLE;
                else if (s_ack && (r_burst_cnt == BURST_LAST) && m0_cyc)
                    w_next = GRANT0;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Saturating at the last beat lets a lone owner keep the grant while staying armed to yield.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_burst_cnt <= '0;
        else if (w_next != r_state)
            r_burst_cnt <= '0;
        else if (w_granted && s_ack && (r_burst_cnt != BURST_LAST))
            r_burst_cnt <= r_burst_cnt + 8'd1;
    end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Self-checking bench for wshb_arbiter: directed scenarios plus randomized traffic vs a grant model.
module tb_wshb_arbiter;
    import wshb_arb_pkg::*;

    localparam int MAX_BURST = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_cyc, m0_stb, m0_we, m0_ack;
    logic [31:0] m0_adr, m0_dat_ms, m0_dat_sm;
    logic [3:0]  m0_sel;
    logic [2:0]  m0_cti;
    logic [1:0]  m0_bte;
    logic        m1_cyc, m1_stb, m1_we, m1_ack;
    logic [31:0] m1_adr, m1_dat_ms, m1_dat_sm;
    logic [3:0]  m1_sel;
    logic [2:0]  m1_cti;
    logic [1:0]  m1_bte;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [31:0] s_adr, s_dat_ms, s_dat_sm;
    logic [3:0]  s_sel;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the slave (-1 none) and acks taken in this tenure (capped).
    int mdl_owner;
    int mdl_acks;

    always #5 clk = ~clk;

    wshb_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
        .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
        .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_ack(s_ack), .s_dat_sm(s_dat_sm)
    );

    function automatic logic [75:0] s_bundle();
        return {s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte};
    endfunction

    function automatic logic [75:0] m_bundle(input int idx);
        if (idx == 0) return {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_ms, m0_sel, m0_cti, m0_bte};
        if (idx == 1) return {m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_ms, m1_sel, m1_cti, m1_bte};
        return '0;
    endfunction

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 32'h0000_1000; m0_dat_ms = 32'h0;
        m0_sel = 4'hF; m0_cti = 3'd0; m0_bte = 2'd0;
        m1_cyc = 0; m1_stb = 0; m1_we = 1; m1_adr = 32'h0000_2000; m1_dat_ms = 32'h1111_2222;
        m1_sel = 4'h3; m1_cti = 3'd2; m1_bte = 2'd1;
        s_ack = 0; s_dat_sm = 32'h0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        m0_cyc = 1; m0_stb = 1; s_ack = 1;
        #1;
        n_cmp++;
        if ({s_bundle(), m0_ack, m1_ack} !== 78'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", {s_bundle(), m0_ack, m1_ack});
        end
        @(negedge clk);
        m0_cyc = 0; m0_stb = 0;
        m1_cyc = 1; m1_stb = 1;
        rst_n = 1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({s_cyc, s_stb, m1_ack} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_pre_grant1: got %b want 111", {s_cyc, s_stb, m1_ack});
        end
        #1 rst_n = 0;
        #1;
        n_cmp++;
        if ({s_cyc, s_stb, m0_ack, m1_ack} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_async_drop: got %b want 0000", {s_cyc, s_stb, m0_ack, m1_ack});
        end
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        n_cmp++;
        if (dut.r_state !== IDLE || s_cyc !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_idle: got state %0d s_cyc %b want 0 0", dut.r_state, s_cyc);
        end
    endtask

    task automatic test_lone_master();
        int acks = 0;
        int bad = 0;
        apply_reset();
        m0_cyc = 1; m0_stb = 1; s_ack = 1; m0_adr = 32'hCAFE_0000;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (m0_ack) acks++;
            if (i > 0 && (s_cyc !== 1'b1 || s_adr !== m0_adr || m1_ack !== 1'b0)) bad++;
            @(negedge clk);
        end
        n_cmp++;
        if (acks != 99) begin
            n_err++;
            $display("FAIL lone_ack_count: got %0d want 99", acks);
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL lone_hold_grant0: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_contention();
        int bad = 0;
        logic [1:0] exp_a;
        apply_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
        for (int c = 0; c < 34; c++) begin
            #1;
            exp_a = (c == 0) ? 2'b00 : (c <= MAX_BURST) ? 2'b10 : (c <= 2 * MAX_BURST) ? 2'b01 : 2'b10;
            if ({m0_ack, m1_ack} !== exp_a) bad++;
            if (c == 1) begin
                n_cmp++;
                if (s_adr !== m0_adr || m0_ack !== 1'b1) begin
                    n_err++;
                    $display("FAIL contention_first_grant0: got adr %h ack %b want %h 1", s_adr, m0_ack, m0_adr);
                end
            end
            if (c == MAX_BURST + 1) begin
                n_cmp++;
                if (s_adr !== m1_adr || m1_ack !== 1'b1) begin
                    n_err++;
                    $display("FAIL contention_handover1: got adr %h ack %b want %h 1", s_adr, m1_ack, m1_adr);
                end
            end
            if (c == 2 * MAX_BURST + 1) begin
                n_cmp++;
                if (s_adr !== m0_adr || m0_ack !== 1'b1) begin
                    n_err++;
                    $display("FAIL contention_return0: got adr %h ack %b want %h 1", s_adr, m0_ack, m0_adr);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL contention_ack_sequence: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_release();
        int acks = 0;
        apply_reset();
        m1_cyc = 1; m1_stb = 1; s_ack = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (m1_ack) acks++;
            @(negedge clk);
        end
        n_cmp++;
        if (acks != 3 || dut.r_burst_cnt !== 8'd3) begin
            n_err++;
            $display("FAIL release_three_acks: got %0d cnt %0d want 3 3", acks, dut.r_burst_cnt);
        end
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        #1;
        n_cmp++;
        if (s_cyc !== 1'b0) begin
            n_err++;
            $display("FAIL release_s_cyc_comb: got %b want 0", s_cyc);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (dut.r_state !== IDLE || s_cyc !== 1'b0 || dut.r_burst_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL release_idle: got state %0d s_cyc %b cnt %0d want 0 0 0",
                     dut.r_state, s_cyc, dut.r_burst_cnt);
        end
    endtask

    task automatic test_ack_isolation();
        apply_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        @(negedge clk);
        s_ack = 1; s_dat_sm = 32'hA5A5_0001;
        #1;
        n_cmp++;
        if ({m0_ack, m1_ack} !== 2'b10) begin
            n_err++;
            $display("FAIL isolation_acks: got %b want 10", {m0_ack, m1_ack});
        end
        n_cmp++;
        if (m0_dat_sm !== 32'hA5A5_0001 || m1_dat_sm !== 32'hA5A5_0001) begin
            n_err++;
            $display("FAIL isolation_dat: got %h %h want a5a50001", m0_dat_sm, m1_dat_sm);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        @(negedge clk);
        m0_cyc = 0;
        #1;
        n_cmp++;
        if (s_cyc !== 1'b0) begin
            n_err++;
            $display("FAIL abort_s_cyc_drop: got %b want 0", s_cyc);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (s_cyc !== 1'b1 || s_adr !== m1_adr || s_we !== m1_we) begin
            n_err++;
            $display("FAIL abort_grant_moves: got cyc %b adr %h want 1 %h", s_cyc, s_adr, m1_adr);
        end
    endtask

    task automatic model_step();
        logic own, oth;
        if (mdl_owner < 0) begin
            mdl_owner = m0_cyc ? 0 : (m1_cyc ? 1 : -1);
            mdl_acks = 0;
        end else begin
            own = (mdl_owner == 0) ? m0_cyc : m1_cyc;
            oth = (mdl_owner == 0) ? m1_cyc : m0_cyc;
            if (!own) begin
                mdl_owner = oth ? 1 - mdl_owner : -1;
                mdl_acks = 0;
            end else if (s_ack) begin
                if (mdl_acks + 1 >= MAX_BURST && oth) begin
                    mdl_owner = 1 - mdl_owner;
                    mdl_acks = 0;
                end else if (mdl_acks + 1 < MAX_BURST) begin
                    mdl_acks++;
                end
            end
        end
    endtask

    task automatic test_random();
        int bad_s = 0, bad_a = 0, bad_d = 0;
        logic [1:0] exp_a;
        apply_reset();
        mdl_owner = -1;
        mdl_acks = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            m0_cyc = ($urandom_range(0, 15) != 0); m0_stb = 1'($urandom); m0_we = 1'($urandom);
            m0_adr = $urandom; m0_dat_ms = $urandom; m0_sel = 4'($urandom);
            m0_cti = 3'($urandom); m0_bte = 2'($urandom);
            m1_cyc = ($urandom_range(0, 5) != 0); m1_stb = 1'($urandom); m1_we = 1'($urandom);
            m1_adr = $urandom; m1_dat_ms = $urandom; m1_sel = 4'($urandom);
            m1_cti = 3'($urandom); m1_bte = 2'($urandom);
            s_ack = ($urandom_range(0, 3) != 0); s_dat_sm = $urandom;
            #1;
            exp_a = {s_ack && (mdl_owner == 0), s_ack && (mdl_owner == 1)};
            n_cmp++;
            if (s_bundle() !== m_bundle(mdl_owner)) begin
                n_err++;
                if (bad_s++ < 5)
                    $display("FAIL random_slave_bundle @%0d: got %h want %h", i, s_bundle(), m_bundle(mdl_owner));
            end
            n_cmp++;
            if ({m0_ack, m1_ack} !== exp_a) begin
                n_err++;
                if (bad_a++ < 5)
                    $display("FAIL random_acks @%0d: got %b want %b", i, {m0_ack, m1_ack}, exp_a);
            end
            n_cmp++;
            if (m0_dat_sm !== s_dat_sm || m1_dat_sm !== s_dat_sm) begin
                n_err++;
                if (bad_d++ < 5)
                    $display("FAIL random_dat_sm @%0d: got %h %h want %h", i, m0_dat_sm, m1_dat_sm, s_dat_sm);
            end
            @(posedge clk);
            model_step();
        end
    endtask

    initial begin
        test_reset();
        test_lone_master();
        test_contention();
        test_release();
        test_ack_isolation();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
